// File: rtl/encoder_4x2_rr_pkg.sv
// Shared constants for the 4-to-2 round-robin request encoder.
// Imported by the encoder top and its pick sub-module.
package encoder_4x2_rr_pkg;

    localparam int ENC_NUM_REQ = 4;
    localparam int ENC_IDX_W   = 2;

    localparam bit ENC_MODE_FIXED = 1'b0;
    localparam bit ENC_MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_pick_4x2.sv
// Combinational 4-way pick: rotate by ptr, take lowest set bit,
// un-rotate. With rr_en low the rotation is bypassed.
module rr_pick_4x2
    import encoder_4x2_rr_pkg::*;
(
    input  logic [3:0] cand,
    input  logic [1:0] ptr,
    input  logic       rr_en,
    output logic [1:0] idx,
    output logic       any
);

    logic [1:0] base;
    logic [7:0] dbl;
    logic [3:0] rot;
    logic [1:0] low;

    assign base = rr_en ? ptr : 2'b00;
    assign dbl  = {cand, cand};
    assign rot  = dbl[base +: 4];

    // lowest set bit of the rotated candidate vector
    always_comb begin
        low = 2'd0;
        priority case (1'b1)
            rot[0]:  low = 2'd0;
            rot[1]:  low = 2'd1;
            rot[2]:  low = 2'd2;
            rot[3]:  low = 2'd3;
            default: low = 2'd0;
        endcase
    end

    assign idx = low + base;
    assign any = |cand;

endmodule

// File: rtl/encoder_4x2_rr.sv
// Registered 4-to-2 request encoder with round-robin or fixed
// priority and a valid/ready output handshake.
module encoder_4x2_rr
    import encoder_4x2_rr_pkg::*;
#(
    parameter bit ROUND_ROBIN = ENC_MODE_RR,
    parameter int NUM_REQ     = ENC_NUM_REQ
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [NUM_REQ-1:0] REQ,
    input  logic               EN,
    input  logic               READY,
    output logic [1:0]         OUT,
    output logic               VALID,
    output logic               OVF
);

    localparam bit RR_EN = (ROUND_ROBIN == ENC_MODE_RR);

    logic [NUM_REQ-1:0] pend_q, pend_d;
    logic [NUM_REQ-1:0] req_en;
    logic [NUM_REQ-1:0] cand;
    logic [1:0]         ptr_q, ptr_d;
    logic [1:0]         out_q, out_d;
    logic               valid_q, valid_d;
    logic               ovf_q, ovf_d;
    logic [1:0]         pick_idx;
    logic               pick_any;
    logic               load;

    assign req_en = REQ & {NUM_REQ{EN}};
    assign cand   = pend_q | req_en;
    assign load   = ~valid_q | READY;

    rr_pick_4x2 u_pick (
        .cand  (cand),
        .ptr   (ptr_q),
        .rr_en (RR_EN),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // next state: reload the output slot when free or being accepted
    always_comb begin
        pend_d  = cand;
        ptr_d   = ptr_q;
        out_d   = out_q;
        valid_d = valid_q;
        ovf_d   = |(req_en & pend_q);
        if (load) begin
            if (pick_any) begin
                out_d   = pick_idx;
                valid_d = 1'b1;
                pend_d  = cand & ~(4'b0001 << pick_idx);
                if (RR_EN) begin
                    ptr_d = pick_idx + 2'd1;
                end
            end else begin
                valid_d = 1'b0;
                pend_d  = '0;
            end
        end
    end

    // state registers, cleared asynchronously
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pend_q  <= '0;
            ptr_q   <= 2'b00;
            out_q   <= 2'b00;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign OUT   = out_q;
    assign VALID = valid_q;
    assign OVF   = ovf_q;

endmodule

// File: tb/tb_encoder_4x2_rr.sv
// Bench for encoder_4x2_rr: one round-robin and one fixed-priority
// instance share stimulus and are checked against a model each cycle.
module tb_encoder_4x2_rr;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [3:0] REQ;
    logic       EN;
    logic       READY;
    logic [1:0] out_rr, out_fx;
    logic       val_rr, val_fx;
    logic       ovf_rr, ovf_fx;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    encoder_4x2_rr #(.ROUND_ROBIN(1'b1), .NUM_REQ(4)) dut_rr (
        .CLK(CLK), .RESET_N(RESET_N), .REQ(REQ), .EN(EN),
        .READY(READY), .OUT(out_rr), .VALID(val_rr), .OVF(ovf_rr)
    );

    encoder_4x2_rr #(.ROUND_ROBIN(1'b0), .NUM_REQ(4)) dut_fx (
        .CLK(CLK), .RESET_N(RESET_N), .REQ(REQ), .EN(EN),
        .READY(READY), .OUT(out_fx), .VALID(val_fx), .OVF(ovf_fx)
    );

    // model state, index 0 = round robin, 1 = fixed priority
    logic [3:0] m_pend [2];
    int         m_ptr  [2];
    int         m_out  [2];
    logic       m_val  [2];
    logic       m_ovf  [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_pend[d] = 4'b0; m_ptr[d] = 0; m_out[d] = 0;
            m_val[d] = 1'b0; m_ovf[d] = 1'b0;
        end
    end

    always @(posedge CLK or negedge RESET_N) begin
        logic [3:0] req, cand;
        int         j, pick;
        if (!RESET_N) begin
            for (int d = 0; d < 2; d++) begin
                m_pend[d] = 4'b0; m_ptr[d] = 0; m_out[d] = 0;
                m_val[d] = 1'b0; m_ovf[d] = 1'b0;
            end
        end else begin
            req = EN ? REQ : 4'b0;
            for (int d = 0; d < 2; d++) begin
                cand     = m_pend[d] | req;
                m_ovf[d] = (req & m_pend[d]) != 4'b0;
                if (!m_val[d] || READY) begin
                    pick = -1;
                    for (int k = 0; k < 4; k++) begin
                        j = (m_ptr[d] + k) % 4;
                        if (pick < 0 && cand[j]) pick = j;
                    end
                    if (pick >= 0) begin
                        m_out[d]   = pick;
                        m_val[d]   = 1'b1;
                        cand[pick] = 1'b0;
                        m_pend[d]  = cand;
                        if (d == 0) m_ptr[d] = (pick + 1) % 4;
                    end else begin
                        m_val[d]  = 1'b0;
                        m_pend[d] = 4'b0;
                    end
                end else begin
                    m_pend[d] = cand;
                end
            end
        end
    end

    // per-cycle comparison of both instances against the model
    always @(negedge CLK) begin
        n_vec++;
        if (int'(out_rr) != m_out[0] || val_rr !== m_val[0]
            || ovf_rr !== m_ovf[0]) begin
            n_err++;
            $display("FAIL model_rr t=%0t got out=%0d v=%b o=%b exp out=%0d v=%b o=%b",
                     $time, out_rr, val_rr, ovf_rr, m_out[0], m_val[0], m_ovf[0]);
        end
        n_vec++;
        if (int'(out_fx) != m_out[1] || val_fx !== m_val[1]
            || ovf_fx !== m_ovf[1]) begin
            n_err++;
            $display("FAIL model_fx t=%0t got out=%0d v=%b o=%b exp out=%0d v=%b o=%b",
                     $time, out_fx, val_fx, ovf_fx, m_out[1], m_val[1], m_ovf[1]);
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    int rr_seq [6] = '{0, 1, 3, 0, 1, 3};

    initial begin
        RESET_N = 1'b0; REQ = 4'hF; EN = 1'b1; READY = 1'b1;
        repeat (3) begin
            tick();
            chk("rst_valid", int'(val_rr), 0);
            chk("rst_out", int'(out_rr), 0);
            chk("rst_ovf", int'(ovf_rr), 0);
        end
        RESET_N = 1'b1;
        tick();
        chk("post_rst_valid", int'(val_rr), 1);
        chk("post_rst_out", int'(out_rr), 0);
        REQ = 4'h0;
        repeat (5) tick();
        chk("drain_idle", int'(val_rr), 0);

        // round robin, continuous 1011
        REQ = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr_valid", int'(val_rr), 1);
            chk("rr_seq", int'(out_rr), rr_seq[i]);
        end
        REQ = 4'h0;
        repeat (6) tick();
        chk("rr_idle", int'(val_rr), 0);

        // backpressure with a late request
        READY = 1'b0; REQ = 4'b0100;
        tick();
        chk("bp_out", int'(out_rr), 2);
        REQ = 4'h0;
        for (int i = 0; i < 5; i++) begin
            REQ = (i == 2) ? 4'b0001 : 4'b0000;
            tick();
            chk("bp_hold_out", int'(out_rr), 2);
            chk("bp_hold_v", int'(val_rr), 1);
        end
        REQ = 4'h0; READY = 1'b1;
        tick();
        chk("bp_next_out", int'(out_rr), 0);
        chk("bp_next_v", int'(val_rr), 1);
        tick();
        chk("bp_done_v", int'(val_rr), 0);

        // fixed priority, single pulses
        REQ = 4'b1110;
        tick();
        chk("fx_a1", int'(out_fx), 1);
        REQ = 4'h0;
        tick();
        chk("fx_a2", int'(out_fx), 2);
        tick();
        chk("fx_a3", int'(out_fx), 3);
        tick();
        chk("fx_a_end", int'(val_fx), 0);
        REQ = 4'b1010;
        tick();
        chk("fx_b1", int'(out_fx), 1);
        REQ = 4'h0;
        tick();
        chk("fx_b3", int'(out_fx), 3);
        tick();
        chk("fx_b_end", int'(val_fx), 0);
        repeat (2) tick();

        // overflow: second request merges into a pending bit
        READY = 1'b0; REQ = 4'b0001;
        tick();
        REQ = 4'b0010;
        tick();
        chk("ovf_first", int'(ovf_rr), 0);
        REQ = 4'h0;
        tick();
        REQ = 4'b0010;
        tick();
        chk("ovf_pulse", int'(ovf_rr), 1);
        REQ = 4'h0;
        tick();
        chk("ovf_clear", int'(ovf_rr), 0);
        READY = 1'b1;
        tick();
        chk("ovf_grant", int'(out_rr), 1);
        tick();
        chk("ovf_single", int'(val_rr), 0);
        repeat (2) tick();

        // EN gating
        EN = 1'b0; REQ = 4'hF;
        repeat (3) begin
            tick();
            chk("en_gate", int'(val_rr), 0);
        end

        // mid-operation async reset
        EN = 1'b1; READY = 1'b0; REQ = 4'b1000;
        tick();
        chk("mid_out", int'(out_rr), 3);
        REQ = 4'b0111;
        tick();
        REQ = 4'h0;
        #2;
        RESET_N = 1'b0;
        #1;
        chk("async_v", int'(val_rr), 0);
        chk("async_out", int'(out_rr), 0);
        chk("async_fx_v", int'(val_fx), 0);
        tick();
        RESET_N = 1'b1; READY = 1'b1;
        repeat (3) begin
            tick();
            chk("post_mid_v", int'(val_rr), 0);
            chk("post_mid_fx_v", int'(val_fx), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
